// File: rtl/status_display_fsm.sv
// Display/LED arbitration for the O/X MLP board: one FSM selects the
// 7-segment source, number/one-hot flag and LED bank among training
// progress, training-complete hold, inference result hold and keypad echo.
module status_display_fsm #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned LED_W          = 8,
  parameter int unsigned PCT_W          = 7,
  parameter int unsigned DONE_HOLD_MS   = 3000,
  parameter int unsigned DONE_LED_MS    = 1000,
  parameter int unsigned RESULT_HOLD_MS = 3000,
  parameter int unsigned ANIM_STEP_CYC  = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             train_active,
  input  logic             train_done,
  input  logic [7:0]       epoch,
  input  logic             key_valid,
  input  logic [3:0]       key_digit,
  input  logic             submit,
  input  logic             nn_y,
  input  logic [PCT_W-1:0] nn_pct,
  output logic [15:0]      seg_data,
  output logic             seg_valid,
  output logic             seg_number_mode,
  output logic [LED_W-1:0] led,
  output logic [2:0]       mode
);

  localparam int unsigned MS_CYC        = CLK_HZ / 1000;
  localparam int unsigned DONE_HOLD_CYC = MS_CYC * DONE_HOLD_MS;
  localparam int unsigned DONE_LED_CYC  = MS_CYC * DONE_LED_MS;
  localparam int unsigned RES_HOLD_CYC  = MS_CYC * RESULT_HOLD_MS;
  localparam int unsigned TMR_MAX       = (DONE_HOLD_CYC > RES_HOLD_CYC) ? DONE_HOLD_CYC : RES_HOLD_CYC;
  localparam int unsigned TW            = $clog2(TMR_MAX) + 1;
  localparam int unsigned AW            = $clog2(ANIM_STEP_CYC) + 1;
  localparam int unsigned PROD_W        = PCT_W + $clog2(LED_W) + 1;

  localparam logic [TW-1:0]    DONE_LAST    = TW'(DONE_HOLD_CYC - 1);
  localparam logic [TW-1:0]    DONE_LED_END = TW'(DONE_LED_CYC);
  localparam logic [TW-1:0]    RES_LAST     = TW'(RES_HOLD_CYC - 1);
  localparam logic [AW-1:0]    ANIM_LAST    = AW'(ANIM_STEP_CYC - 1);
  localparam logic [PCT_W-1:0] PCT_MAX      = PCT_W'(100);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_RESULT = 3'd2,
    ST_TRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               done_q, sub_q;
  logic [TW-1:0]      dtmr_q, dtmr_d;
  logic [TW-1:0]      rtmr_q, rtmr_d;
  logic [AW-1:0]      acnt_q, acnt_d;
  logic [LED_W-1:0]   anim_q, anim_d;
  logic [3:0]         digit_q, digit_d;
  logic               y_q, y_d;
  logic [PCT_W-1:0]   pct_q, pct_d;
  logic [15:0]        seg_data_d;
  logic               seg_valid_d, seg_nm_d;
  logic [LED_W-1:0]   led_d;
  logic [LED_W-1:0]   res_led;
  logic [PROD_W-1:0]  prod, therm_n;
  logic               done_rise, sub_rise;

  assign done_rise = train_done & ~done_q;
  assign sub_rise  = submit & ~sub_q;
  assign mode      = state_q;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    return {4'(v / 8'd100), 4'((v % 8'd100) / 8'd10), 4'(v % 8'd10)};
  endfunction

  // Result LED pattern: y on the MSB, thermometer of max(1, pct*(LED_W-1)/100) below it.
  always_comb begin
    res_led = '0;
    prod    = PROD_W'(pct_d) * PROD_W'(LED_W - 1);
    therm_n = prod / PROD_W'(100);
    if (therm_n == '0) therm_n = PROD_W'(1);
    for (int unsigned i = 0; i < LED_W - 1; i++) res_led[i] = (PROD_W'(i) < therm_n);
    res_led[LED_W-1] = y_d;
  end

  // Next-state, timers and latches in priority order, then outputs.
  // Outputs decode the next-state values so the registered outputs
  // reflect an input on the same edge that samples it.
  always_comb begin
    state_d = state_q;
    dtmr_d  = dtmr_q;
    rtmr_d  = rtmr_q;
    acnt_d  = acnt_q;
    anim_d  = anim_q;
    digit_d = digit_q;
    y_d     = y_q;
    pct_d   = pct_q;

    if (done_rise) begin
      state_d = ST_DONE;
      dtmr_d  = '0;
    end else if (state_q == ST_DONE) begin
      if (dtmr_q == DONE_LAST) begin
        state_d = train_active ? ST_TRAIN : ST_IDLE;
        dtmr_d  = '0;
        acnt_d  = '0;
        anim_d  = LED_W'(1);
      end else begin
        dtmr_d = dtmr_q + 1'b1;
      end
    end else if (train_active) begin
      state_d = ST_TRAIN;
      if (state_q != ST_TRAIN) begin
        acnt_d = '0;
        anim_d = LED_W'(1);
      end else if (acnt_q == ANIM_LAST) begin
        acnt_d = '0;
        anim_d = {anim_q[LED_W-2:0], anim_q[LED_W-1]};
      end else begin
        acnt_d = acnt_q + 1'b1;
      end
    end else if (state_q == ST_TRAIN) begin
      state_d = ST_IDLE;
    end else if (sub_rise) begin
      state_d = ST_RESULT;
      y_d     = nn_y;
      pct_d   = (nn_pct > PCT_MAX) ? PCT_MAX : nn_pct;
      rtmr_d  = '0;
    end else if (state_q == ST_RESULT) begin
      if (!submit) begin
        if (rtmr_q == RES_LAST) begin
          state_d = ST_IDLE;
        end else if (key_valid) begin
          state_d = ST_KEY;
          digit_d = key_digit;
        end else begin
          rtmr_d = rtmr_q + 1'b1;
        end
      end
    end else if (key_valid) begin
      state_d = ST_KEY;
      digit_d = key_digit;
    end else begin
      state_d = ST_IDLE;
    end

    seg_data_d  = '0;
    seg_valid_d = 1'b1;
    seg_nm_d    = 1'b1;
    led_d       = '0;
    case (state_d)
      ST_KEY:    seg_data_d = {12'h000, digit_d};
      ST_RESULT: begin
        seg_data_d = {4'h0, to_bcd(8'(pct_d))};
        led_d      = res_led;
      end
      ST_TRAIN:  begin
        seg_data_d = {4'h0, to_bcd(epoch)};
        led_d      = anim_d;
      end
      ST_DONE:   begin
        seg_data_d = 16'h0099;
        led_d      = (dtmr_d < DONE_LED_END) ? '1 : '0;
      end
      default:   begin
        seg_valid_d = 1'b0;
        seg_nm_d    = 1'b0;
      end
    endcase
  end

  // State, timers, latches, edge history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      done_q          <= 1'b0;
      sub_q           <= 1'b0;
      dtmr_q          <= '0;
      rtmr_q          <= '0;
      acnt_q          <= '0;
      anim_q          <= '0;
      digit_q         <= '0;
      y_q             <= 1'b0;
      pct_q           <= '0;
      seg_data        <= '0;
      seg_valid       <= 1'b0;
      seg_number_mode <= 1'b0;
      led             <= '0;
    end else begin
      state_q         <= state_d;
      done_q          <= train_done;
      sub_q           <= submit;
      dtmr_q          <= dtmr_d;
      rtmr_q          <= rtmr_d;
      acnt_q          <= acnt_d;
      anim_q          <= anim_d;
      digit_q         <= digit_d;
      y_q             <= y_d;
      pct_q           <= pct_d;
      seg_data        <= seg_data_d;
      seg_valid       <= seg_valid_d;
      seg_number_mode <= seg_nm_d;
      led             <= led_d;
    end
  end

endmodule

// File: tb/tb_status_display_fsm.sv
// Directed bench for status_display_fsm with 1 ms = 1 cycle timing.
module tb_status_display_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        train_active = 1'b0;
  logic        train_done = 1'b0;
  logic [7:0]  epoch = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = '0;
  logic        submit = 1'b0;
  logic        nn_y = 1'b0;
  logic [6:0]  nn_pct = '0;
  logic [15:0] seg_data;
  logic        seg_valid;
  logic        seg_number_mode;
  logic [7:0]  led;
  logic [2:0]  mode;

  int total = 0;
  int bad   = 0;

  status_display_fsm #(
    .CLK_HZ(1000), .LED_W(8), .PCT_W(7), .DONE_HOLD_MS(30), .DONE_LED_MS(10),
    .RESULT_HOLD_MS(20), .ANIM_STEP_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .train_active(train_active), .train_done(train_done),
    .epoch(epoch), .key_valid(key_valid), .key_digit(key_digit), .submit(submit),
    .nn_y(nn_y), .nn_pct(nn_pct), .seg_data(seg_data), .seg_valid(seg_valid),
    .seg_number_mode(seg_number_mode), .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [2:0] m, input logic [15:0] s,
                      input logic v, input logic [7:0] l);
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".seg"}, 32'(seg_data), 32'(s));
    chk({tag, ".valid"}, 32'(seg_valid), 32'(v));
    chk({tag, ".nmode"}, 32'(seg_number_mode), 32'(v));
    chk({tag, ".led"}, 32'(led), 32'(l));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    #1 rst = 1'b1;
    #2 outs("reset", 3'd0, 16'h0000, 1'b0, 8'h00);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) begin step; outs("idle", 3'd0, 16'h0000, 1'b0, 8'h00); end

    // keypad echo
    key_valid = 1'b1; key_digit = 4'hA;
    repeat (3) begin step; outs("key", 3'd1, 16'h000A, 1'b1, 8'h00); end
    key_valid = 1'b0;
    step; outs("keyrel", 3'd0, 16'h0000, 1'b0, 8'h00);

    // result 57 %, O; input changes after the edge are ignored
    nn_pct = 7'd57; nn_y = 1'b1; submit = 1'b1;
    step; outs("res57", 3'd2, 16'h0057, 1'b1, 8'h87);
    nn_pct = 7'd10;
    repeat (4) begin step; outs("res57held", 3'd2, 16'h0057, 1'b1, 8'h87); end
    submit = 1'b0;
    repeat (19) begin step; outs("res57hold", 3'd2, 16'h0057, 1'b1, 8'h87); end
    step; outs("res57exp", 3'd0, 16'h0000, 1'b0, 8'h00);

    // result clamp 120 -> 100, then keypad aborts the hold
    nn_pct = 7'd120; nn_y = 1'b1; submit = 1'b1;
    step; outs("res120", 3'd2, 16'h0100, 1'b1, 8'hFF);
    step; outs("res120held", 3'd2, 16'h0100, 1'b1, 8'hFF);
    submit = 1'b0;
    repeat (5) begin step; outs("res120hold", 3'd2, 16'h0100, 1'b1, 8'hFF); end
    key_valid = 1'b1; key_digit = 4'h3;
    step; outs("keyabort", 3'd1, 16'h0003, 1'b1, 8'h00);

    // submit edge from KEY, pct 0 / X gives a single thermometer LED
    key_valid = 1'b0; nn_pct = 7'd0; nn_y = 1'b0; submit = 1'b1;
    step; outs("res0", 3'd2, 16'h0000, 1'b1, 8'h01);

    // training preempts RESULT; running LED every 4 cycles with wrap
    train_active = 1'b1; epoch = 8'd12; submit = 1'b0;
    for (int k = 0; k < 36; k++) begin
      e = 8'h01 << ((k / 4) % 8);
      step; outs("train", 3'd3, 16'h0012, 1'b1, e);
    end
    epoch = 8'd255;
    step; outs("epoch255", 3'd3, 16'h0255, 1'b1, 8'h02);

    // training completes: 10 cycles all-on, IDLE after 30, submit ignored
    train_done = 1'b1; train_active = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      if (k == 15) submit = 1'b1;
      if (k == 17) submit = 1'b0;
      step;
      if (k < 30) outs("done", 3'd4, 16'h0099, 1'b1, (k < 10) ? 8'hFF : 8'h00);
      else        outs("doneexp", 3'd0, 16'h0000, 1'b0, 8'h00);
    end

    // simultaneous done edge and submit edge while in RESULT
    train_done = 1'b0;
    step; outs("idle2", 3'd0, 16'h0000, 1'b0, 8'h00);
    nn_pct = 7'd42; nn_y = 1'b0; submit = 1'b1;
    step; outs("res42", 3'd2, 16'h0042, 1'b1, 8'h03);
    submit = 1'b0;
    step; outs("res42rel", 3'd2, 16'h0042, 1'b1, 8'h03);
    submit = 1'b1; train_done = 1'b1;
    step; outs("both", 3'd4, 16'h0099, 1'b1, 8'hFF);
    step; outs("both1", 3'd4, 16'h0099, 1'b1, 8'hFF);

    // asynchronous reset mid-DONE, then a level held through reset
    #2 rst = 1'b1;
    #1 outs("asyncrst", 3'd0, 16'h0000, 1'b0, 8'h00);
    rst = 1'b0; submit = 1'b0;
    step; outs("lvlrel", 3'd4, 16'h0099, 1'b1, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
